icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter FRAMES, default 16, number of direct-mapped one-word frames (power of 2, 2..256).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imemREN  input  1  datapath instruction read request.
REQ-005 SHALL have port imemaddr  input  32  datapath instruction byte address.
REQ-006 SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word returned to datapath.
REQ-008 SHALL have port iREN  output  1  read request to memory controller.
REQ-009 SHALL have port iaddr  output  32  word-aligned memory read address.
REQ-010 SHALL have port iwait  input  1  memory busy; read data not yet valid while high.
REQ-011 SHALL have port iload  input  32  memory read data, valid when iREN=1 and iwait=0.

Function
REQ-012 SHALL split imemaddr into tag [31:2+log2(FRAMES)], index [1+log2(FRAMES):2], offset [1:0]; offset ignored.
REQ-013 SHALL hold per frame: valid bit, tag, 32-bit data word.
REQ-014 SHALL implement FSM states IDLE and FILL.
REQ-015 In IDLE: ihit = imemREN & valid[index] & (tag[index]==tag), combinational, same-cycle.
REQ-016 imemload SHALL equal data[index] whenever ihit=1; value is don't-care otherwise.
REQ-017 IDLE->FILL when imemREN=1 and lookup misses; miss address latched into a fill register on that edge.
REQ-018 In FILL: iREN=1, iaddr = {latched address[31:2], 2'b00}; ihit=0.
REQ-019 FILL->IDLE on the edge where iwait=0; same edge writes valid=1, latched tag, iload into latched index.
REQ-020 FILL SHALL complete even if imemREN drops or imemaddr changes mid-fill; no abort path.
REQ-021 After return to IDLE, a repeated request hits the following cycle; miss latency = memory latency + 2 cycles from request to ihit.
REQ-022 In IDLE, iREN=0 and iaddr=0.
REQ-023 Fill to an occupied frame SHALL overwrite it (direct-mapped eviction, no writeback).
REQ-024 imemREN=0 in IDLE SHALL produce ihit=0 and no state change.

Reset
REQ-025 nRST low SHALL immediately force FSM to IDLE, clear all valid bits, clear fill register, drive iREN=0, iaddr=0, ihit=0.
REQ-026 Reset asserted during FILL SHALL abandon the fill; no frame written; iREN drops asynchronously.
REQ-027 Tag and data arrays need not be reset; valid bits gate all use.

Configuration
REQ-028 With macro ICACHE_STATS_EN defined, SHALL add outputs hit_count (32, output) and miss_count (32, output).
REQ-029 hit_count SHALL increment on each cycle with ihit=1 in IDLE; miss_count on each IDLE->FILL transition; both saturate at 32'hFFFFFFFF; both reset to 0.
REQ-030 Without ICACHE_STATS_EN, the counters and ports SHALL not exist; all other behaviour identical.

Verification
REQ-031 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait high 3 cycles then low with iload=0x8C010004 -> iREN high 4 cycles, iaddr=0x40, ihit=1 with imemload=0x8C010004 one cycle after fill.
REQ-032 Hit: after REQ-031, request 0x00000042 -> ihit=1 same cycle, imemload=0x8C010004, iREN stays 0.
REQ-033 Conflict eviction (FRAMES=16): fill 0x00000000 then 0x00000040 (same index 0) -> second is a miss; subsequent 0x00000000 misses again.
REQ-034 Reset mid-fill: assert nRST low during FILL with iwait=1 -> iREN=0 immediately; after release, request same address misses.
REQ-035 Request drop: miss on 0x00000080, deassert imemREN in FILL -> fill completes; later request of 0x00000080 hits with no iREN.
REQ-036 With ICACHE_STATS_EN: 1 miss then 5 hit cycles -> miss_count=1, hit_count=5.

Source files
------------

// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped, one-word-per-frame instruction cache controller.
//
// A lookup is combinational: a valid frame whose tag matches the request
// answers in the same cycle. A miss latches the request address and holds a
// read request to memory until iwait falls; on that edge the frame is
// written and the controller returns to IDLE. The next cycle hits.
//
// Parameters:
//   FRAMES      number of frames (power of 2, 2..256)
// Ports:
//   CLK         clock, rising edge
//   nRST        asynchronous active-low reset
//   imemREN     datapath read request
//   imemaddr    datapath byte address (offset bits ignored)
//   ihit        imemload holds the requested word this cycle
//   imemload    instruction word to the datapath
//   iREN        read request to the memory controller
//   iaddr       word-aligned memory read address (0 when idle)
//   iwait       memory busy
//   iload       memory read data
// Optional build macro ICACHE_STATS_EN adds:
//   hit_count   saturating count of hit cycles
//   miss_count  saturating count of misses (IDLE->FILL transitions)

module icache_ctrl #(
  parameter int unsigned FRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IW = $clog2(FRAMES);
  localparam int unsigned TW = 30 - IW;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_fill_addr;
  logic [FRAMES-1:0] r_valid;
  logic [TW-1:0]     r_tag  [FRAMES];
  logic [31:0]       r_data [FRAMES];

  logic [IW-1:0]     w_idx;
  logic [TW-1:0]     w_tag;
  logic [IW-1:0]     w_fill_idx;
  logic [TW-1:0]     w_fill_tag;
  logic              w_lookup_hit;
  logic              w_miss;
  logic              w_fill_done;
  logic              w_unused;

  assign w_idx        = imemaddr[IW+1:2];
  assign w_tag        = imemaddr[31:IW+2];
  assign w_fill_idx   = r_fill_addr[IW+1:2];
  assign w_fill_tag   = r_fill_addr[31:IW+2];
  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign imemload     = r_data[w_idx];
  // Byte offset of the latched address never reaches memory.
  assign w_unused     = ^r_fill_addr[1:0];

  always_comb begin
    w_state_next = r_state;
    ihit         = 1'b0;
    iREN         = 1'b0;
    iaddr        = '0;
    w_miss       = 1'b0;
    w_fill_done  = 1'b0;
    case (r_state)
      IDLE: begin
        ihit = imemREN && w_lookup_hit;
        if (imemREN && !w_lookup_hit) begin
          w_miss       = 1'b1;
          w_state_next = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {r_fill_addr[31:2], 2'b00};
        if (!iwait) begin
          w_fill_done  = 1'b1;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_fill_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss) begin
        r_fill_addr <= imemaddr;
      end
      if (w_fill_done) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays are unreset; reset parks the FSM in IDLE so no write
  // can occur while nRST is low, and the cleared valid bits gate all reads.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (ihit && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl (FRAMES=16). A reference model tracks cache
// contents as a map from frame number to the cached word address and data,
// plus whether a miss is outstanding; a compare process checks the DUT
// against it every cycle. Directed sequences add literal expectations.
// Build with ICACHE_STATS_EN to also check hit_count/miss_count.

module tb_icache_ctrl;

  localparam int unsigned FRAMES = 16;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_ctrl #(.FRAMES(FRAMES)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } line_t;

  line_t       m_line [int unsigned];
  bit          m_busy = 1'b0;
  logic [31:0] m_fill = '0;
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  function automatic int unsigned frame_of(input logic [31:0] a);
    return (a >> 2) % FRAMES;
  endfunction

  function automatic bit cached(input logic [31:0] a);
    int unsigned k;
    k = frame_of(a);
    return m_line.exists(k) && (m_line[k].waddr == a[31:2]);
  endfunction

  initial begin
    bit          e_hit;
    bit          e_busy;
    logic [31:0] e_addr;
    forever begin
      @(negedge CLK);
      #2;
      e_busy = nRST && m_busy;
      e_hit  = nRST && !m_busy && imemREN && cached(imemaddr);
      e_addr = e_busy ? {m_fill[31:2], 2'b00} : 32'h0;
      chk("model ihit", {31'b0, ihit}, {31'b0, e_hit});
      chk("model iREN", {31'b0, iREN}, {31'b0, e_busy});
      chk("model iaddr", iaddr, e_addr);
      if (e_hit) chk("model imemload", imemload, m_line[frame_of(imemaddr)].data);
`ifdef ICACHE_STATS_EN
      chk("model hit_count", hit_count, m_hits);
      chk("model miss_count", miss_count, m_misses);
`endif
      @(posedge CLK);
      if (!nRST) begin
        m_line.delete();
        m_busy   = 1'b0;
        m_hits   = 0;
        m_misses = 0;
      end else if (m_busy) begin
        if (!iwait) begin
          m_line[frame_of(m_fill)] = '{waddr: m_fill[31:2], data: iload};
          m_busy = 1'b0;
        end
      end else if (imemREN) begin
        if (cached(imemaddr)) m_hits++;
        else begin
          m_busy   = 1'b1;
          m_fill   = imemaddr;
          m_misses++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change on the falling edge; returns 3 time units later so the
  // caller can inspect this cycle's combinational outputs.
  task automatic drive(input logic req, input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge CLK);
    imemREN  = req;
    imemaddr = a;
    iwait    = w;
    iload    = d;
    #3;
  endtask

  // Miss on a, memory busy for lat cycles, then returns d.
  task automatic do_fill(input logic [31:0] a, input int unsigned lat, input logic [31:0] d,
                         output bit missed, output int unsigned ren_cycles);
    drive(1'b1, a, 1'b1, 32'h0);
    missed     = !ihit;
    ren_cycles = 0;
    for (int unsigned i = 0; i < lat; i++) begin
      drive(1'b1, a, 1'b1, 32'h0);
      ren_cycles += iREN;
    end
    drive(1'b1, a, 1'b0, d);
    ren_cycles += iREN;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          missed;
    int unsigned ren;

    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iwait    = 1'b1;
    iload    = '0;
    repeat (2) @(negedge CLK);
    #3;
    chk("reset ihit", {31'b0, ihit}, 32'd0);
    chk("reset iREN", {31'b0, iREN}, 32'd0);
    chk("reset iaddr", iaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Cold miss, memory latency 3
    do_fill(32'h40, 3, 32'h8C010004, missed, ren);
    chk("cold miss", {31'b0, missed}, 32'd1);
    chk("cold iREN cycles", ren, 32'd4);
    drive(1'b1, 32'h40, 1'b1, 32'h0);
    chk("cold then hit", {31'b0, ihit}, 32'd1);
    chk("cold imemload", imemload, 32'h8C010004);

    // Hit with nonzero byte offset
    drive(1'b1, 32'h42, 1'b1, 32'h0);
    chk("offset hit", {31'b0, ihit}, 32'd1);
    chk("offset imemload", imemload, 32'h8C010004);
    chk("offset iREN", {31'b0, iREN}, 32'd0);

    // No request in IDLE: no hit even though the word is cached
    drive(1'b0, 32'h40, 1'b1, 32'h0);
    chk("idle no req ihit", {31'b0, ihit}, 32'd0);
    chk("idle no req iREN", {31'b0, iREN}, 32'd0);

    // Conflict eviction on frame 0, plus a neighbouring frame unaffected
    do_fill(32'h0, 1, 32'h11111111, missed, ren);
    chk("conflict 0x0 miss", {31'b0, missed}, 32'd1);
    do_fill(32'h44, 0, 32'h22222222, missed, ren);
    chk("frame1 miss", {31'b0, missed}, 32'd1);
    chk("zero latency iREN cycles", ren, 32'd1);
    do_fill(32'h40, 2, 32'h33333333, missed, ren);
    chk("conflict 0x40 miss", {31'b0, missed}, 32'd1);
    do_fill(32'h0, 0, 32'h44444444, missed, ren);
    chk("evicted 0x0 misses again", {31'b0, missed}, 32'd1);
    drive(1'b1, 32'h44, 1'b1, 32'h0);
    chk("frame1 still hits", {31'b0, ihit}, 32'd1);
    chk("frame1 data", imemload, 32'h22222222);
    drive(1'b1, 32'h0, 1'b1, 32'h0);
    chk("refilled 0x0 data", imemload, 32'h44444444);

    // Top frame, high tag
    do_fill(32'hFFFF_FFFC, 1, 32'hCAFEF00D, missed, ren);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0);
    chk("top frame hit", {31'b0, ihit}, 32'd1);
    chk("top frame data", imemload, 32'hCAFEF00D);

    // Reset mid-fill
    drive(1'b1, 32'h100, 1'b1, 32'h0);
    drive(1'b1, 32'h100, 1'b1, 32'h0);
    chk("pre-reset fill iREN", {31'b0, iREN}, 32'd1);
    chk("pre-reset fill iaddr", iaddr, 32'h100);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    chk("async reset iREN", {31'b0, iREN}, 32'd0);
    chk("async reset iaddr", iaddr, 32'h0);
    drive(1'b1, 32'h100, 1'b0, 32'hDEADBEEF);
    drive(1'b1, 32'h100, 1'b0, 32'hDEADBEEF);
    @(negedge CLK);
    nRST     = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    iwait    = 1'b1;
    #3;
    chk("after reset 0x100 misses", {31'b0, ihit}, 32'd0);
    drive(1'b1, 32'h100, 1'b0, 32'h55555555);
    drive(1'b1, 32'h100, 1'b1, 32'h0);
    chk("0x100 filled", imemload, 32'h55555555);
    drive(1'b1, 32'h44, 1'b1, 32'h0);
    chk("reset cleared frame1", {31'b0, ihit}, 32'd0);
    drive(1'b1, 32'h44, 1'b0, 32'h66666666);

    // Request drop mid-fill
    drive(1'b1, 32'h80, 1'b1, 32'h0);
    drive(1'b0, 32'h1234_5678, 1'b1, 32'h0);
    chk("drop fill iaddr", iaddr, 32'h80);
    drive(1'b0, 32'h0, 1'b0, 32'h77777777);
    chk("drop fill iREN", {31'b0, iREN}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b1, 32'h80, 1'b1, 32'h0);
    chk("dropped fill hits", {31'b0, ihit}, 32'd1);
    chk("dropped fill data", imemload, 32'h77777777);
    chk("dropped fill no iREN", {31'b0, iREN}, 32'd0);

`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    do_fill(32'h200, 1, 32'h99999999, missed, ren);
    for (int unsigned i = 0; i < 5; i++) drive(1'b1, 32'h200, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    chk("stats miss_count", miss_count, 32'd1);
    chk("stats hit_count", hit_count, 32'd5);
`endif

    drive(1'b0, 32'h0, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
